// File: rtl/fsm_serial_pkg.sv
// fsm_serial_pkg
//   Shared definitions for the serial transmitter and the serial receiver:
//   the frame state type and the fixed frame constants.
package fsm_serial_pkg;

    localparam int unsigned DATA_BITS   = 8;
    localparam logic        IDLE_LEVEL  = 1'b1;
    localparam logic        START_LEVEL = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } serial_state_e;

endpackage

// File: rtl/serial_tx_hold.sv
// serial_tx_hold
//   One-entry hold register with a ready/valid input side.
//   Ports:
//     clk        - clock, rising edge
//     reset      - synchronous, active-high
//     in_byte    - byte offered by the producer
//     in_valid   - in_byte is valid this cycle
//     in_ready   - register is empty and accepts in_byte this cycle
//     take       - consumer unloads the held byte on this edge
//     hold_byte  - held byte
//     hold_valid - hold_byte is valid
module serial_tx_hold
    import fsm_serial_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] in_byte,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 take,
    output logic [DATA_BITS-1:0] hold_byte,
    output logic                 hold_valid
);

    logic accept;

    assign in_ready = !hold_valid;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_byte  <= '0;
        end else begin
            // A new byte wins over an unload so a same-edge refill stays full.
            if (accept) begin
                hold_byte  <= in_byte;
                hold_valid <= 1'b1;
            end else if (take) begin
                hold_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fsm_serial_tx.sv
// fsm_serial_tx
//   Serial transmitter: start bit, 8 data bits LSB first, optional parity,
//   one or two stop bits; one bit per clk cycle, line idles high.
//   Parameters:
//     PARITY_EN  - 1 inserts a parity bit after the last data bit
//     PARITY_ODD - 0 even parity, 1 odd parity
//     STOP_BITS  - 1 or 2
//   Ports:
//     clk      - clock, rising edge
//     reset    - synchronous, active-high
//     in_byte  - byte to transmit
//     in_valid - in_byte is valid this cycle
//     in_ready - byte is accepted this cycle
//     out      - serial line
//     busy     - frame on the line or a byte held
//     done     - pulse during the final stop-bit cycle
module fsm_serial_tx
    import fsm_serial_pkg::*;
#(
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] in_byte,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 out,
    output logic                 busy,
    output logic                 done
);

    localparam logic       USE_PARITY = (PARITY_EN != 0);
    localparam logic       ODD_PARITY = (PARITY_ODD != 0);
    localparam logic       TWO_STOPS  = (STOP_BITS == 2);
    localparam logic [2:0] LAST_BIT   = 3'(DATA_BITS - 1);

    serial_state_e        state;
    logic [DATA_BITS-1:0] shift;
    logic [2:0]           bit_cnt;
    logic                 par_acc;
    logic [DATA_BITS-1:0] hold_byte;
    logic                 hold_valid;
    logic                 at_last_stop;
    logic                 load;

    assign at_last_stop = TWO_STOPS ? (state == STOP2) : (state == STOP1);
    // Load from IDLE or straight out of the last stop bit (back-to-back).
    assign load = hold_valid && ((state == IDLE) || at_last_stop);
    assign busy = (state != IDLE) || hold_valid;

    serial_tx_hold u_hold (
        .clk        (clk),
        .reset      (reset),
        .in_byte    (in_byte),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .take       (load),
        .hold_byte  (hold_byte),
        .hold_valid (hold_valid)
    );

    // out and done are registered with the next state, so each reflects the
    // state the FSM is in during the following cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            par_acc <= 1'b0;
            out     <= IDLE_LEVEL;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                state <= START;
                shift <= hold_byte;
                out   <= START_LEVEL;
            end else begin
                case (state)
                    IDLE: begin
                        out <= IDLE_LEVEL;
                    end
                    START: begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        par_acc <= ODD_PARITY;
                        out     <= shift[0];
                    end
                    DATA: begin
                        shift   <= shift >> 1;
                        par_acc <= par_acc ^ shift[0];
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt != LAST_BIT) begin
                            out <= shift[1];
                        end else if (USE_PARITY) begin
                            state <= PARITY;
                            out   <= par_acc ^ shift[0];
                        end else begin
                            state <= STOP1;
                            out   <= IDLE_LEVEL;
                            done  <= !TWO_STOPS;
                        end
                    end
                    PARITY: begin
                        state <= STOP1;
                        out   <= IDLE_LEVEL;
                        done  <= !TWO_STOPS;
                    end
                    STOP1: begin
                        out <= IDLE_LEVEL;
                        if (TWO_STOPS) begin
                            state <= STOP2;
                            done  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    STOP2: begin
                        state <= IDLE;
                        out   <= IDLE_LEVEL;
                    end
                    default: begin
                        state <= IDLE;
                        out   <= IDLE_LEVEL;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/fsm_serial_tx.md
FSM_SERIAL_TX -- requirements
Module: fsm_serial_tx

Interface
REQ-001 SHALL have parameter PARITY_EN, default 0; 1 inserts a parity bit after B7.
REQ-002 SHALL have parameter PARITY_ODD, default 0; 0 selects even parity, 1 selects odd parity; ignored when PARITY_EN=0.
REQ-003 SHALL have parameter STOP_BITS, default 1; legal values are 1 and 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in_byte, input, 8 bits: the byte to transmit.
REQ-007 SHALL have port in_valid, input, 1 bit: in_byte is valid this cycle.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts in_byte this cycle.
REQ-009 SHALL have port out, output, 1 bit: the serial line, one bit per clk cycle, idle high.
REQ-010 SHALL have port busy, output, 1 bit: a frame is on the line or a byte is held.
REQ-011 SHALL have port done, output, 1 bit: single-cycle pulse marking the final stop-bit cycle.

Function
REQ-012 SHALL transfer a byte on any rising edge where in_valid=1 and in_ready=1; the byte is captured into a one-entry hold register.
REQ-013 SHALL drive in_ready = !hold_valid; in_ready has no combinational path from in_valid.
REQ-014 SHALL use FSM states IDLE, START, DATA (3-bit bit counter 0..7), PARITY, STOP1 and STOP2.
REQ-015 SHALL move IDLE->START on the edge after hold_valid=1, load the shift register from the hold register and clear hold_valid on that same edge.
REQ-016 SHALL sequence START->DATA, with DATA lasting 8 cycles LSB first, ->PARITY (only if PARITY_EN) ->STOP1 ->STOP2 (only if STOP_BITS=2).
REQ-017 SHALL, from the last stop state, go to START if hold_valid=1 (back-to-back, no idle cycle), else to IDLE.
REQ-018 SHALL decode out from registers only: 1 in IDLE/STOP1/STOP2, 0 in START, shift[0] in DATA, XOR of the data bits (inverted if PARITY_ODD) in PARITY.
REQ-019 SHALL make the frame length 10 + PARITY_EN + (STOP_BITS-1) cycles.
REQ-020 SHALL make latency from accept edge k to the start bit: out=0 in the cycle following edge k+1, when the FSM was IDLE.
REQ-021 SHALL allow capture of a new byte into the hold register while a frame is in progress; that byte starts immediately after the current frame's last stop bit.
REQ-022 SHALL assert done only during the last stop-bit cycle of each frame.
REQ-023 SHALL set busy = (state != IDLE) | hold_valid.
REQ-024 SHALL, on simultaneous hold-register unload and new accept in the same edge, store the new byte and keep hold_valid=1.
REQ-025 SHALL leave in_byte without effect when no transfer occurs, and SHALL NOT corrupt the frame in flight.

Reset
REQ-026 SHALL, while reset=1, on each edge set state=IDLE, hold_valid=0 and shift=0.
REQ-027 SHALL, in the cycle after a reset edge, drive out=1, done=0, busy=0 and in_ready=1.
REQ-028 SHALL, on reset mid-frame, abort the frame, discard any held byte and return the line to 1 on the next cycle with no done pulse.

Structure
REQ-029 SHALL put the state enum type and frame constants (DATA_BITS=8, IDLE_LEVEL=1, START_LEVEL=0) in shared package fsm_serial_pkg, which the existing serial receiver also uses.
REQ-030 SHALL implement the one-entry hold register with ready/valid as sub-module serial_tx_hold; the FSM, shift register and parity accumulator stay in fsm_serial_tx.

Verification
REQ-031 SHALL cover this case with defaults: send 0xA5 -> out = 0,1,0,1,0,0,1,0,1,1; done high on the 10th bit cycle only.
REQ-032 SHALL cover this case: 0x00 and 0xFF presented back-to-back with in_valid held -> 20 contiguous frame cycles, no idle 1 between frames, and in_ready low while the hold register is full.
REQ-033 SHALL cover this case with PARITY_EN=1: 0xA5 -> parity bit 0 (even) and 1 with PARITY_ODD=1; 11-cycle frame.
REQ-034 SHALL cover this case with STOP_BITS=2: 0x3C -> two stop bits of 1; done on the second stop bit only.
REQ-035 SHALL cover this case: reset asserted during DATA bit 4 with a byte held -> out=1 the next cycle, busy=0, no done pulse, and the next accepted byte transmits correctly.
REQ-036 SHALL cover this case: loopback into the existing serial receiver with 256 random bytes -> every receiver done carries out_byte equal to the sent byte, with no errors.
